// File: rtl/w_input_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, single-cycle press pulse w,
// debounced level, busy flag and a wrapping 4-bit press counter.
//   state | meaning
//   IDLE  | debounced level 0, waiting for a 1 sample
//   RISE  | qualifying a press, cnt = consecutive 1 samples seen
//   HIGH  | debounced level 1, waiting for a 0 sample
//   FALL  | qualifying a release, cnt = consecutive 0 samples seen
module w_input_conditioner #(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   output logic       w,
   output logic       level,
   output logic       busy,
   output logic [3:0] presses
);

   typedef enum logic [1:0] {IDLE, RISE, HIGH, FALL} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             s1, s2;
   logic             level_nx, w_nx;
   logic [3:0]       presses_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         state   <= IDLE;
         cnt     <= '0;
         level   <= 1'b0;
         w       <= 1'b0;
         presses <= 4'd0;
      end else begin
         s1      <= btn;
         s2      <= s1;
         state   <= state_nx;
         cnt     <= cnt_nx;
         level   <= level_nx;
         w       <= w_nx;
         presses <= presses_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = level;
      w_nx       = 1'b0;
      presses_nx = presses;
      unique case (state)
         IDLE: begin
            if (s2) begin
               state_nx = RISE;
               cnt_nx   = CNT_ONE;
            end
         end
         RISE: begin
            if (!s2) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx   = HIGH;
               cnt_nx     = '0;
               level_nx   = 1'b1;
               w_nx       = 1'b1;
               presses_nx = presses + 4'd1;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         HIGH: begin
            if (!s2) begin
               state_nx = FALL;
               cnt_nx   = CNT_ONE;
            end
         end
         FALL: begin
            // a 1 sample here is a release bounce: drop back to HIGH silently
            if (s2) begin
               state_nx = HIGH;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               level_nx = 1'b0;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign busy = (state == RISE) || (state == FALL);

endmodule

// File: tb/tb_w_input_conditioner.sv
// Directed bench for w_input_conditioner (DEBOUNCE=4): inputs driven and outputs sampled
// on the falling edge, so each tick() spans exactly one rising edge.
module tb_w_input_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic       w;
   logic       level;
   logic       busy;
   logic [3:0] presses;

   int total = 0;
   int bad   = 0;
   int wcount = 0;

   w_input_conditioner #(.DEBOUNCE(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .btn(btn),
      .w(w), .level(level), .busy(busy), .presses(presses)
   );

   always #1 clk = ~clk;

   always @(negedge clk) if (w === 1'b1) wcount++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int wbase;

   initial begin
      // 1: reset with button held, then fresh pulse 6 edges after first sampling edge
      rst = 1'b1;
      btn = 1'b1;
      tick(2);
      chk("rst_w", w, 0);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_presses", presses, 0);
      rst = 1'b0;
      tick(5);
      chk("held_w_early", w, 0);
      chk("held_busy", busy, 1);
      tick(1);
      chk("held_w", w, 1);
      chk("held_level", level, 1);
      chk("held_presses", presses, 1);
      chk("held_busy_low", busy, 0);
      tick(1);
      chk("held_w_single", w, 0);

      // release: level falls 6 edges after btn first sampled low
      btn = 1'b0;
      tick(5);
      chk("rel_level_hold", level, 1);
      chk("rel_busy", busy, 1);
      tick(1);
      chk("rel_level", level, 0);
      chk("rel_busy_low", busy, 0);
      tick(4);

      // 2: clean press, held 10 cycles
      wbase = wcount;
      btn = 1'b1;
      tick(5);
      chk("clean_w_early", w, 0);
      chk("clean_level_early", level, 0);
      tick(1);
      chk("clean_w", w, 1);
      chk("clean_level", level, 1);
      chk("clean_presses", presses, 2);
      tick(4);
      btn = 1'b0;
      tick(6);
      chk("clean_level_rel", level, 0);
      tick(4);
      chk("clean_wcount", wcount - wbase, 1);

      // 3: press glitch of 2 cycles
      wbase = wcount;
      btn = 1'b1;
      tick(2);
      btn = 1'b0;
      tick(1);
      chk("glitch_busy1", busy, 1);
      tick(1);
      chk("glitch_busy2", busy, 1);
      tick(1);
      chk("glitch_busy_end", busy, 0);
      chk("glitch_level", level, 0);
      tick(6);
      chk("glitch_wcount", wcount - wbase, 0);
      chk("glitch_presses", presses, 2);

      // 4: release bounce of 2 cycles while HIGH
      btn = 1'b1;
      tick(8);
      chk("bounce_pre_level", level, 1);
      chk("bounce_pre_presses", presses, 3);
      wbase = wcount;
      btn = 1'b0;
      tick(2);
      btn = 1'b1;
      tick(1);
      chk("bounce_busy1", busy, 1);
      chk("bounce_level1", level, 1);
      tick(1);
      chk("bounce_busy2", busy, 1);
      tick(1);
      chk("bounce_busy_end", busy, 0);
      chk("bounce_level", level, 1);
      tick(8);
      chk("bounce_wcount", wcount - wbase, 0);
      chk("bounce_presses", presses, 3);

      // 5: counter wrap over 16 presses from a fresh reset
      btn = 1'b0;
      tick(8);
      rst = 1'b1;
      tick(1);
      chk("wrap_rst_presses", presses, 0);
      rst = 1'b0;
      wbase = wcount;
      for (int i = 0; i < 16; i++) begin
         btn = 1'b1;
         tick(8);
         chk("wrap_presses", presses, (i + 1) % 16);
         btn = 1'b0;
         tick(8);
      end
      chk("wrap_wcount", wcount - wbase, 16);
      chk("wrap_final", presses, 0);

      // 6: reset one cycle after RISE entered
      btn = 1'b1;
      tick(3);
      chk("midrise_busy", busy, 1);
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("midrise_rst_busy", busy, 0);
      chk("midrise_rst_w", w, 0);
      chk("midrise_rst_level", level, 0);
      chk("midrise_rst_presses", presses, 0);
      rst = 1'b0;
      tick(5);
      chk("midrise_w_early", w, 0);
      tick(1);
      chk("midrise_w", w, 1);
      chk("midrise_presses", presses, 1);
      tick(1);
      chk("midrise_w_single", w, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
